// File: rtl/id_target_ras.sv
// id_target_ras: decode-stage control-flow target prediction backed by a circular return-address stack
module id_target_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [XLEN-1:0]              in_pc,
  input  logic [31:0]                  in_instr,
  input  logic                         stall,
  input  logic                         flush,
  output logic                         out_valid,
  output logic [XLEN-1:0]              out_pc,
  output logic [XLEN-1:0]              out_target,
  output logic [1:0]                   out_kind,
  output logic                         out_ras_hit,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [XLEN-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]   sp;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1;
  logic            is_jal, is_jalr, is_br, rd_link, rs1_link;
  logic            push, pop, empty, full, accept;
  logic            do_push, do_pop, do_rep;
  logic [XLEN-1:0] i_imm, b_imm, j_imm, top, link_addr, target;
  logic [1:0]      kind;
  logic            hit;
  logic [PW-1:0]   wr_idx;
  always_comb begin
    opcode    = in_instr[6:0];
    rd        = in_instr[11:7];
    rs1       = in_instr[19:15];
    is_jal    = opcode == 7'b1101111;
    is_jalr   = opcode == 7'b1100111;
    is_br     = opcode == 7'b1100011;
    rd_link   = rd == 5'd1 || rd == 5'd5;
    rs1_link  = rs1 == 5'd1 || rs1 == 5'd5;
    i_imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    b_imm     = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    j_imm     = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    push      = (is_jal | is_jalr) & rd_link;
    pop       = is_jalr & rs1_link & ~(rd_link & rs1 == rd);
    empty     = ras_count == '0;
    full      = ras_count == (PW+1)'(RAS_DEPTH);
    accept    = in_valid & ~stall & ~flush;
    top       = ras[sp - PW'(1)];
    link_addr = in_pc + XLEN'(4);
    // a pop+push on a non-empty stack rewrites the top in place
    do_rep    = push & pop & ~empty;
    do_push   = push & ~do_rep;
    do_pop    = pop & ~push & ~empty;
    wr_idx    = do_rep ? sp - PW'(1) : sp;
    hit       = is_jalr & pop & ~empty;
    target    = is_br ? in_pc + b_imm :
                is_jal ? in_pc + j_imm :
                hit ? top : in_pc + i_imm;
    kind      = is_jal ? 2'b10 : is_jalr ? 2'b11 : is_br ? 2'b01 : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      ras_count <= '0;
    end else if (accept & do_push) begin
      sp        <= sp + PW'(1);
      ras_count <= full ? ras_count : ras_count + 1'b1;
    end else if (accept & do_pop) begin
      sp        <= sp - PW'(1);
      ras_count <= ras_count - 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst && accept && push) ras[wr_idx] <= link_addr;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_target  <= '0;
      out_kind    <= 2'b00;
      out_ras_hit <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      out_pc      <= in_pc;
      out_target  <= target;
      out_kind    <= kind;
      out_ras_hit <= hit;
    end
  end
endmodule
